// File: rtl/fume_panel_cmd.sv
// Front-panel command generator for the fume-extractor mode controller:
// button debounce, user-interaction FSM, hurricane lockout and delayed return.
module fume_panel_cmd #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned RET_DELAY = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_s1,
    input  logic       btn_s2,
    input  logic       btn_s3,
    input  logic       btn_back,
    input  logic       in_work,
    input  logic [1:0] speed,
    input  logic [5:0] timer,
    output logic       mode_sel,
    output logic [1:0] speed_sel,
    output logic       manual_return,
    output logic       hurricane_lock,
    output logic [5:0] ret_count
);

    localparam int unsigned NBTN = 5;
    localparam int unsigned CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    localparam int unsigned B_S1   = 0;
    localparam int unsigned B_S2   = 1;
    localparam int unsigned B_S3   = 2;
    localparam int unsigned B_MODE = 3;
    localparam int unsigned B_BACK = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_HURR,
        S_RET_WAIT,
        S_RET_PULSE
    } state_t;

    logic [NBTN-1:0]         btn_raw;
    logic [NBTN-1:0]         sync1_q, sync2_q;
    logic [NBTN-1:0]         level_q, level_d;
    logic [NBTN-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NBTN-1:0]         press;

    logic ev_back, ev_mode, ev_s3, ev_s2, ev_s1;

    state_t     state_q, state_d;
    logic       mode_sel_q, mode_sel_d;
    logic [1:0] speed_sel_q, speed_sel_d;
    logic       manual_return_q, manual_return_d;
    logic       lock_q, lock_d;
    logic [5:0] ret_q, ret_d;
    logic [1:0] settle_q, settle_d;

    logic unused_in_work;

    assign unused_in_work = in_work;
    assign btn_raw = {btn_back, btn_mode, btn_s3, btn_s2, btn_s1};

    // Press fires in the cycle the DB_CYCLES-th equal sample is seen, so the
    // FSM acts on the same edge that commits the new level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press   = '0;
        for (int unsigned i = 0; i < NBTN; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
                press[i]   = sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    assign ev_back = press[B_BACK];
    assign ev_mode = press[B_MODE] & ~press[B_BACK];
    assign ev_s3   = press[B_S3] & ~press[B_BACK] & ~press[B_MODE];
    assign ev_s2   = press[B_S2] & ~press[B_BACK] & ~press[B_MODE] & ~press[B_S3];
    assign ev_s1   = press[B_S1] & ~press[B_BACK] & ~press[B_MODE] & ~press[B_S3] & ~press[B_S2];

    always_comb begin
        state_d         = state_q;
        mode_sel_d      = mode_sel_q;
        speed_sel_d     = speed_sel_q;
        manual_return_d = 1'b0;
        lock_d          = lock_q;
        ret_d           = ret_q;
        settle_d        = settle_q;
        unique case (state_q)
            S_IDLE: begin
                mode_sel_d  = 1'b0;
                speed_sel_d = 2'b00;
                if (ev_mode) begin
                    state_d    = S_RUN;
                    mode_sel_d = 1'b1;
                end
            end
            S_RUN: begin
                if (ev_back) begin
                    state_d         = S_RET_PULSE;
                    manual_return_d = 1'b1;
                end else if (ev_mode) begin
                    state_d     = S_IDLE;
                    mode_sel_d  = 1'b0;
                    speed_sel_d = 2'b00;
                end else if (ev_s3) begin
                    if (!lock_q) begin
                        state_d     = S_HURR;
                        speed_sel_d = 2'b10;
                        lock_d      = 1'b1;
                        settle_d    = 2'd2;
                    end else begin
                        speed_sel_d = 2'b01;
                    end
                end else if (ev_s2) begin
                    speed_sel_d = 2'b01;
                end else if (ev_s1) begin
                    speed_sel_d = 2'b00;
                end
            end
            S_HURR: begin
                // Settle masks stale gear/timer feedback from before hurricane was granted.
                if (ev_back) begin
                    state_d     = S_RET_WAIT;
                    ret_d       = 6'(RET_DELAY);
                    speed_sel_d = 2'b01;
                end else if (ev_mode) begin
                    state_d     = S_IDLE;
                    mode_sel_d  = 1'b0;
                    speed_sel_d = 2'b00;
                end else if (settle_q != 2'd0) begin
                    settle_d = settle_q - 2'd1;
                end else if (speed == 2'b01 && timer == 6'd0) begin
                    state_d     = S_RUN;
                    speed_sel_d = 2'b01;
                end
            end
            S_RET_WAIT: begin
                if (ev_mode) begin
                    state_d     = S_IDLE;
                    ret_d       = '0;
                    mode_sel_d  = 1'b0;
                    speed_sel_d = 2'b00;
                end else if (ev_s1 || ev_s2) begin
                    state_d     = S_RUN;
                    ret_d       = '0;
                    speed_sel_d = ev_s2 ? 2'b01 : 2'b00;
                end else if (ret_q == 6'd0) begin
                    state_d         = S_RET_PULSE;
                    manual_return_d = 1'b1;
                end else begin
                    ret_d = ret_q - 6'd1;
                end
            end
            S_RET_PULSE: begin
                state_d     = S_IDLE;
                mode_sel_d  = 1'b0;
                speed_sel_d = 2'b00;
            end
            default: begin
                state_d     = S_IDLE;
                mode_sel_d  = 1'b0;
                speed_sel_d = 2'b00;
                ret_d       = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q         <= '0;
            sync2_q         <= '0;
            level_q         <= '0;
            cnt_q           <= '0;
            state_q         <= S_IDLE;
            mode_sel_q      <= 1'b0;
            speed_sel_q     <= 2'b00;
            manual_return_q <= 1'b0;
            lock_q          <= 1'b0;
            ret_q           <= '0;
            settle_q        <= '0;
        end else begin
            sync1_q         <= btn_raw;
            sync2_q         <= sync1_q;
            level_q         <= level_d;
            cnt_q           <= cnt_d;
            state_q         <= state_d;
            mode_sel_q      <= mode_sel_d;
            speed_sel_q     <= speed_sel_d;
            manual_return_q <= manual_return_d;
            lock_q          <= lock_d;
            ret_q           <= ret_d;
            settle_q        <= settle_d;
        end
    end

    assign mode_sel       = mode_sel_q;
    assign speed_sel      = speed_sel_q;
    assign manual_return  = manual_return_q;
    assign hurricane_lock = lock_q;
    assign ret_count      = ret_q;

endmodule
